vita49_router_n: RTL and testbench
==================================

Name: vita49_router_n

Overview:
- Parametrised N-way VITA-49 packet router for 64-bit AXI-Stream.
- Inspects the first beat of each packet and compares its stream ID against NUM_DEST programmable stream-ID/mask entries.
- Tags every beat of the packet with the matching M_AXIS_TDEST, or drops the packet, or sends it to a default destination.
- Sits between the VITA-49 packetiser/DMA stream and an AXIS interconnect/switch. Configuration is driven by a separate register-interface block in the same clock domain; per-packet counters are returned to it.

Parameters:
- NUM_DEST, 4: number of routing table entries / destinations (2..16).
- DEST_W, 2: width of M_AXIS_TDEST; must satisfy 2**DEST_W >= NUM_DEST.
- DEFAULT_DEST, 0: TDEST used for unmatched packets when cfg_drop_unmatched=0.
- CNT_W, 32: width of statistics counters.

Ports:
- AXIS_ACLK  in  1  single clock for all logic.
- AXIS_ARESETN  in  1  asynchronous, active-low reset.
- S_AXIS_TDATA  in  64  input beat; first beat of a packet has [63:32]=VITA-49 header, [31:0]=stream ID.
- S_AXIS_TVALID  in  1  input valid.
- S_AXIS_TLAST  in  1  last beat of packet.
- S_AXIS_TREADY  out  1  input ready.
- M_AXIS_TDATA  out  64  output beat.
- M_AXIS_TSTRB  out  8  constant 8'hFF.
- M_AXIS_TLAST  out  1  last beat.
- M_AXIS_TDEST  out  DEST_W  routed destination.
- M_AXIS_TVALID  out  1  output valid.
- M_AXIS_TREADY  in  1  output ready.
- cfg_enable  in  1  0 = drop every packet.
- cfg_drop_unmatched  in  1  1 = drop unmatched packets; 0 = route them to DEFAULT_DEST.
- cfg_strm_id  in  NUM_DEST*32  entry i occupies bits [32i+31:32i].
- cfg_strm_mask  in  NUM_DEST*32  1 = compare this bit.
- cfg_entry_en  in  NUM_DEST  per-entry valid.
- stat_routed  out  CNT_W  packets forwarded (counted at TLAST accept).
- stat_dropped  out  CNT_W  packets dropped (counted at TLAST accept).
- stat_clr  in  1  synchronous clear of both counters.

Behaviour:
- Reset state (async assert, sync-release assumed upstream):
  - M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, M_AXIS_TDEST=0.
  - S_AXIS_TREADY=0 while AXIS_ARESETN low.
  - stat_routed=0, stat_dropped=0, FSM=IDLE.
- Match rule: entry i hits when cfg_entry_en[i] && ((S_AXIS_TDATA[31:0] ^ id_i) & mask_i)==0.
  - Lowest index wins.
  - A mask of all zeros matches any ID.
- FSM states:
  - IDLE: awaiting the first beat of a packet.
  - FWD: forwarding the packet to the latched destination.
  - DROP: consuming the rest of an unwanted packet.
- Transitions on an accepted first beat in IDLE:
  - cfg_enable=0, or no hit with cfg_drop_unmatched=1 → DROP; the beat is not output.
  - Otherwise latch dest (hit index or DEFAULT_DEST), output the beat, go to FWD.
  - If TLAST is set on that beat, stay in IDLE and count the packet (routed or dropped) that cycle.
- FWD: forward every beat with the latched dest. Return to IDLE on an accepted TLAST; stat_routed++.
- DROP: S_AXIS_TREADY=1 unconditionally; discard beats. Return to IDLE on an accepted TLAST; stat_dropped++.
- Output register: single-entry registered slice.
  - S_AXIS_TREADY = !M_AXIS_TVALID || M_AXIS_TREADY in IDLE and FWD.
  - An accepted beat appears on M_AXIS one cycle after acceptance (latency 1).
  - Full throughput of 1 beat/cycle when M_AXIS_TREADY=1.
- AXIS rules on M_AXIS:
  - TVALID, TDATA, TLAST and TDEST are held stable while TVALID && !TREADY.
  - TVALID never depends combinationally on TREADY.
- Config is sampled only on the first beat. Changes mid-packet affect only the next packet.
- Counters wrap at 2**CNT_W. stat_clr has priority over a same-cycle increment; the result is 0.
- Reset mid-packet aborts the packet: the output slot is cleared and the next beat after reset is treated as a first beat.

Test Plan:
- Entry0 id=0x1000_0001 mask=FFFFFFFF en; send a 4-beat packet with ID 0x1000_0001 and M_AXIS_TREADY=1 → 4 beats out, latency 1, TDEST=0 on all, TLAST on beat 4, stat_routed=1.
- Entries 1 and 2 both match ID 0xABCD_0000 (entry1 mask=FFFF0000, entry2 exact) → TDEST=1 (lowest index wins).
- Unmatched ID 0xDEAD_BEEF, 3 beats:
  - with cfg_drop_unmatched=1 → no M_AXIS_TVALID, S_AXIS_TREADY=1 throughout, stat_dropped=1;
  - with cfg_drop_unmatched=0, DEFAULT_DEST=3 → TDEST=3.
- Backpressure: toggle M_AXIS_TREADY 1/0 every cycle during an 8-beat packet → output data and order identical to input, no beat lost or duplicated, M_AXIS signals stable while stalled.
- Back-to-back single-beat packets (TLAST on header) with IDs for entries 0, 1, 0 and TREADY=1 → three consecutive output beats with TDEST 0, 1, 0; stat_routed=3.
- Mid-packet: change cfg_strm_id and assert stat_clr at the same time as a TLAST accept → the current packet keeps its dest and counters read 0. Then assert AXIS_ARESETN low mid-packet → M_AXIS_TVALID=0 immediately and the next beat is routed as a new header.

Source files
------------

// File: rtl/vita49_router_n.sv
// N-way VITA-49 stream-ID router: classifies each packet on its first beat,
// tags every forwarded beat with TDEST, or discards the packet.
module vita49_router_n #(
   parameter int NUM_DEST     = 4,
   parameter int DEST_W       = 2,
   parameter int DEFAULT_DEST = 0,
   parameter int CNT_W        = 32
) (
   input  logic                   AXIS_ACLK,
   input  logic                   AXIS_ARESETN,
   input  logic [63:0]            S_AXIS_TDATA,
   input  logic                   S_AXIS_TVALID,
   input  logic                   S_AXIS_TLAST,
   output logic                   S_AXIS_TREADY,
   output logic [63:0]            M_AXIS_TDATA,
   output logic [7:0]             M_AXIS_TSTRB,
   output logic                   M_AXIS_TLAST,
   output logic [DEST_W-1:0]      M_AXIS_TDEST,
   output logic                   M_AXIS_TVALID,
   input  logic                   M_AXIS_TREADY,
   input  logic                   cfg_enable,
   input  logic                   cfg_drop_unmatched,
   input  logic [NUM_DEST*32-1:0] cfg_strm_id,
   input  logic [NUM_DEST*32-1:0] cfg_strm_mask,
   input  logic [NUM_DEST-1:0]    cfg_entry_en,
   output logic [CNT_W-1:0]       stat_routed,
   output logic [CNT_W-1:0]       stat_dropped,
   input  logic                   stat_clr,
   output logic [1:0]             dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t            state_q;
   logic [DEST_W-1:0] dest_q;
   logic              m_valid_q;
   logic [63:0]       m_data_q;
   logic              m_last_q;
   logic [DEST_W-1:0] m_dest_q;
   logic [CNT_W-1:0]  routed_q, routed_d;
   logic [CNT_W-1:0]  dropped_q, dropped_d;

   logic              hit;
   logic [DEST_W-1:0] hit_idx;
   logic              s_ready;
   logic              accept;
   logic              drop_hdr;
   logic [DEST_W-1:0] hdr_dest;
   logic              pkt_routed;
   logic              pkt_dropped;

   // Scan from the top down so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_DEST - 1; i >= 0; i--) begin
         if (cfg_entry_en[i] &&
             (((S_AXIS_TDATA[31:0] ^ cfg_strm_id[32*i +: 32]) & cfg_strm_mask[32*i +: 32]) == 32'd0)) begin
            hit     = 1'b1;
            hit_idx = DEST_W'(i);
         end
      end
   end

   // Valid/ready: a beat moves when VALID and READY are both high at a rising edge;
   // the output slot may refill in the same cycle it drains.
   assign s_ready  = AXIS_ARESETN && ((state_q == DROP) || !m_valid_q || M_AXIS_TREADY);
   assign accept   = S_AXIS_TVALID && s_ready;
   assign drop_hdr = !cfg_enable || (!hit && cfg_drop_unmatched);
   assign hdr_dest = hit ? hit_idx : DEST_W'(DEFAULT_DEST);

   assign pkt_routed  = accept && S_AXIS_TLAST &&
                        (((state_q == IDLE) && !drop_hdr) || (state_q == FWD));
   assign pkt_dropped = accept && S_AXIS_TLAST &&
                        (((state_q == IDLE) && drop_hdr) || (state_q == DROP));

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         state_q   <= IDLE;
         dest_q    <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         m_dest_q  <= '0;
      end else begin
         if (m_valid_q && M_AXIS_TREADY) begin
            m_valid_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (drop_hdr) begin
                     if (!S_AXIS_TLAST) state_q <= DROP;
                  end else begin
                     m_valid_q <= 1'b1;
                     m_data_q  <= S_AXIS_TDATA;
                     m_last_q  <= S_AXIS_TLAST;
                     m_dest_q  <= hdr_dest;
                     dest_q    <= hdr_dest;
                     if (!S_AXIS_TLAST) state_q <= FWD;
                  end
               end
            end
            FWD: begin
               if (accept) begin
                  m_valid_q <= 1'b1;
                  m_data_q  <= S_AXIS_TDATA;
                  m_last_q  <= S_AXIS_TLAST;
                  m_dest_q  <= dest_q;
                  if (S_AXIS_TLAST) state_q <= IDLE;
               end
            end
            DROP: begin
               if (accept && S_AXIS_TLAST) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Clear wins over a same-cycle packet completion.
   always_comb begin
      routed_d  = routed_q;
      dropped_d = dropped_q;
      if (pkt_routed)  routed_d  = routed_q + CNT_W'(1);
      if (pkt_dropped) dropped_d = dropped_q + CNT_W'(1);
      if (stat_clr) begin
         routed_d  = '0;
         dropped_d = '0;
      end
   end

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         routed_q  <= '0;
         dropped_q <= '0;
      end else begin
         routed_q  <= routed_d;
         dropped_q <= dropped_d;
      end
   end

   assign S_AXIS_TREADY = s_ready;
   assign M_AXIS_TDATA  = m_data_q;
   assign M_AXIS_TSTRB  = 8'hFF;
   assign M_AXIS_TLAST  = m_last_q;
   assign M_AXIS_TDEST  = m_dest_q;
   assign M_AXIS_TVALID = m_valid_q;
   assign stat_routed   = routed_q;
   assign stat_dropped  = dropped_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_vita49_router_n.sv
// Bench for vita49_router_n: directed scenarios plus randomized packets, scored
// against a packet-level routing model and an expected-beat queue.
module tb_vita49_router_n;

   localparam int NUM_DEST     = 4;
   localparam int DEST_W       = 2;
   localparam int DEFAULT_DEST = 3;
   localparam int CNT_W        = 32;
   localparam int BW           = 1 + DEST_W + 64;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [63:0]            s_tdata = '0;
   logic                   s_tvalid = 1'b0;
   logic                   s_tlast = 1'b0;
   logic                   s_tready;
   logic [63:0]            m_tdata;
   logic [7:0]             m_tstrb;
   logic                   m_tlast;
   logic [DEST_W-1:0]      m_tdest;
   logic                   m_tvalid;
   logic                   m_tready = 1'b1;
   logic                   cfg_enable = 1'b1;
   logic                   cfg_drop_unmatched = 1'b1;
   logic [NUM_DEST*32-1:0] cfg_strm_id = '0;
   logic [NUM_DEST*32-1:0] cfg_strm_mask = '0;
   logic [NUM_DEST-1:0]    cfg_entry_en = '0;
   logic [CNT_W-1:0]       stat_routed;
   logic [CNT_W-1:0]       stat_dropped;
   logic                   stat_clr = 1'b0;
   logic [1:0]             dbg_state;

   vita49_router_n #(
      .NUM_DEST(NUM_DEST), .DEST_W(DEST_W), .DEFAULT_DEST(DEFAULT_DEST), .CNT_W(CNT_W)
   ) dut (
      .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
      .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast),
      .S_AXIS_TREADY(s_tready),
      .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TLAST(m_tlast),
      .M_AXIS_TDEST(m_tdest), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
      .cfg_enable(cfg_enable), .cfg_drop_unmatched(cfg_drop_unmatched),
      .cfg_strm_id(cfg_strm_id), .cfg_strm_mask(cfg_strm_mask), .cfg_entry_en(cfg_entry_en),
      .stat_routed(stat_routed), .stat_dropped(stat_dropped), .stat_clr(stat_clr),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   // 0: always ready, 1: toggle every cycle, 2: random
   int bp_mode = 0;
   always @(posedge clk) begin
      #1;
      case (bp_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = ~m_tready;
         default: m_tready = 1'($urandom_range(0, 1));
      endcase
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   logic [BW-1:0] exp_q[$];
   int            exp_cyc_q[$];
   int            exp_routed = 0;
   int            exp_dropped = 0;
   bit            in_pkt = 0;
   int            cur_route = -1;

   // Destination for a packet whose first beat carries this ID; -1 means discard.
   function automatic int route(input logic [31:0] id);
      if (!cfg_enable) return -1;
      for (int i = 0; i < NUM_DEST; i++) begin
         if (cfg_entry_en[i] && (((id ^ cfg_strm_id[32*i +: 32]) & cfg_strm_mask[32*i +: 32]) == 0))
            return i;
      end
      return cfg_drop_unmatched ? -1 : DEFAULT_DEST;
   endfunction

   task automatic model_accept(input logic [63:0] data, input bit last);
      if (!in_pkt) cur_route = route(data[31:0]);
      if (cur_route >= 0) begin
         exp_q.push_back({last, DEST_W'(cur_route), data});
         exp_cyc_q.push_back(bp_mode == 0 ? cyc + 1 : -1);
      end
      if (last) begin
         if (cur_route >= 0) exp_routed++;
         else exp_dropped++;
         in_pkt = 0;
      end else begin
         in_pkt = 1;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_cyc_q.delete();
      in_pkt = 0;
      exp_routed = 0;
      exp_dropped = 0;
   endtask

   // ---------------- scoreboard / monitor ----------------
   bit            stalled = 0;
   logic [BW-1:0] held;

   always @(negedge clk) begin
      if (!rst_n) begin
         stalled = 0;
      end else begin
         if (stalled) begin
            check_val("hold_valid", BW'(m_tvalid), BW'(1));
            check_val("hold_beat", {m_tlast, m_tdest, m_tdata}, held);
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               check_val("unexpected_beat", BW'(1), BW'(0));
            end else begin
               logic [BW-1:0] e;
               int            ec;
               e  = exp_q.pop_front();
               ec = exp_cyc_q.pop_front();
               check_val("beat", {m_tlast, m_tdest, m_tdata}, e);
               if (ec >= 0) check_val("latency", BW'(cyc), BW'(ec));
            end
         end
         stalled = m_tvalid && !m_tready;
         held    = {m_tlast, m_tdest, m_tdata};
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_beat(input logic [63:0] data, input bit last, output int waits);
      bit acc;
      bit clr;
      s_tvalid = 1'b1;
      s_tdata  = data;
      s_tlast  = last;
      waits    = 0;
      forever begin
         @(negedge clk);
         acc = s_tready;
         clr = stat_clr;
         if (acc) model_accept(data, last);
         @(posedge clk);
         #1;
         if (clr) begin
            exp_routed  = 0;
            exp_dropped = 0;
         end
         if (acc) break;
         waits++;
         if (waits > 200) begin
            check_val("accept_timeout", BW'(0), BW'(1));
            break;
         end
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_pkt(input logic [31:0] id, input int len, output int waits_total);
      logic [63:0] d;
      int          w;
      waits_total = 0;
      for (int b = 0; b < len; b++) begin
         d = (b == 0) ? {$urandom(), id} : {$urandom(), $urandom()};
         send_beat(d, b == len - 1, w);
         waits_total += w;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0 && !m_tvalid) break;
         @(posedge clk);
         #1;
      end
      check_val("drain_empty", BW'(exp_q.size()), BW'(0));
   endtask

   task automatic check_stats(input string tag);
      check_val({tag, "_routed"}, BW'(stat_routed), BW'(exp_routed));
      check_val({tag, "_dropped"}, BW'(stat_dropped), BW'(exp_dropped));
   endtask

   task automatic clear_stats();
      stat_clr = 1'b1;
      @(posedge clk);
      #1;
      stat_clr = 1'b0;
      exp_routed  = 0;
      exp_dropped = 0;
   endtask

   task automatic set_entry(input int i, input logic [31:0] id, input logic [31:0] mask, input bit en);
      cfg_strm_id[32*i +: 32]   = id;
      cfg_strm_mask[32*i +: 32] = mask;
      cfg_entry_en[i]           = en;
   endtask

   task automatic default_cfg();
      set_entry(0, 32'h1000_0001, 32'hFFFF_FFFF, 1'b1);
      set_entry(1, 32'hABCD_0000, 32'hFFFF_0000, 1'b1);
      set_entry(2, 32'hABCD_0000, 32'hFFFF_FFFF, 1'b1);
      set_entry(3, 32'h5555_0000, 32'hFFFF_FF00, 1'b1);
      cfg_enable         = 1'b1;
      cfg_drop_unmatched = 1'b1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int          w;
      logic [31:0] id;
      logic [31:0] ids [4];

      default_cfg();
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_m_tvalid", BW'(m_tvalid), BW'(0));
      check_val("rst_m_tdata", BW'(m_tdata), BW'(0));
      check_val("rst_m_tlast", BW'(m_tlast), BW'(0));
      check_val("rst_m_tdest", BW'(m_tdest), BW'(0));
      check_val("rst_s_tready", BW'(s_tready), BW'(0));
      check_val("rst_stat_routed", BW'(stat_routed), BW'(0));
      check_val("rst_stat_dropped", BW'(stat_dropped), BW'(0));
      check_val("rst_state", BW'(dbg_state), BW'(0));
      check_val("tstrb", BW'(m_tstrb), BW'(8'hFF));
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // exact match on entry 0
      send_pkt(32'h1000_0001, 4, w);
      drain();
      check_stats("exact");

      // entries 1 and 2 both hit; 1 must win
      send_pkt(32'hABCD_0000, 2, w);
      drain();

      // unmatched, dropped: never stalls, never emits
      send_pkt(32'hDEAD_BEEF, 3, w);
      check_val("drop_ready", BW'(w), BW'(0));
      drain();
      check_stats("drop");

      // unmatched, routed to the default destination
      cfg_drop_unmatched = 1'b0;
      send_pkt(32'hDEAD_BEEF, 3, w);
      drain();
      cfg_drop_unmatched = 1'b1;

      // disabled router drops even a matching packet
      cfg_enable = 1'b0;
      send_pkt(32'h1000_0001, 2, w);
      drain();
      cfg_enable = 1'b1;
      check_stats("disable");

      // alternating backpressure over an 8-beat packet
      bp_mode = 1;
      repeat (2) @(posedge clk);
      #1;
      send_pkt(32'h1000_0001, 8, w);
      drain();
      bp_mode = 0;
      repeat (2) @(posedge clk);
      #1;

      // back-to-back single-beat packets
      clear_stats();
      send_pkt(32'h1000_0001, 1, w);
      send_pkt(32'hABCD_1234, 1, w);
      send_pkt(32'h1000_0001, 1, w);
      drain();
      check_stats("b2b");
      check_val("b2b_routed_3", BW'(stat_routed), BW'(3));

      // config change mid-packet, clear coincident with the closing beat
      send_beat({32'h0, 32'hABCD_0042}, 1'b0, w);
      set_entry(0, 32'h0, 32'h0, 1'b1);
      set_entry(1, 32'h1111_0000, 32'hFFFF_FFFF, 1'b1);
      send_beat({$urandom(), $urandom()}, 1'b0, w);
      stat_clr = 1'b1;
      send_beat({$urandom(), $urandom()}, 1'b1, w);
      stat_clr = 1'b0;
      drain();
      check_stats("clr_mid");
      check_val("clr_routed_0", BW'(stat_routed), BW'(0));
      default_cfg();

      // reset in the middle of a packet
      send_beat({32'h0, 32'h1000_0001}, 1'b0, w);
      send_beat({$urandom(), $urandom()}, 1'b0, w);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_val("midrst_m_tvalid", BW'(m_tvalid), BW'(0));
      check_val("midrst_s_tready", BW'(s_tready), BW'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_pkt(32'hABCD_0000, 2, w);
      drain();
      check_stats("after_rst");

      // randomized traffic
      ids[0] = 32'h1000_0001;
      ids[1] = 32'hABCD_0000;
      ids[2] = 32'h5555_0000;
      ids[3] = 32'h0000_0000;
      for (int p = 0; p < 160; p++) begin
         if (p % 20 == 0) begin
            drain();
            bp_mode = $urandom_range(0, 2);
            cfg_entry_en = NUM_DEST'($urandom_range(0, (1 << NUM_DEST) - 1));
            repeat (2) @(posedge clk);
            #1;
         end
         id = ids[$urandom_range(0, 3)];
         case ($urandom_range(0, 3))
            0:       id = $urandom();
            1:       id[15:0] = 16'($urandom());
            2:       id[7:0] = 8'($urandom());
            default: ;
         endcase
         cfg_drop_unmatched = 1'($urandom_range(0, 1));
         cfg_enable         = ($urandom_range(0, 9) != 0);
         send_pkt(id, $urandom_range(1, 6), w);
         if ($urandom_range(0, 29) == 0) clear_stats();
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      drain();
      check_stats("final");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
